// File: rtl/ram_rtl_pkg.sv
// Shared constants and types for the ram_4096 FIFO controller slice.
package ram_rtl_pkg;

  localparam int RAM_DATA_WIDTH = 64;
  localparam int RAM_ADDR_WIDTH = 12;
  localparam int RAM_DEPTH      = 4096;

  typedef logic [11:0] ram_addr_t;
  typedef logic [63:0] ram_data_t;

endpackage : ram_rtl_pkg

// File: rtl/ram_fifo_ptr.sv
// Free-running FIFO address pointer: advances by one on each enabled edge and
// wraps from all-ones back to zero through plain binary overflow.
module ram_fifo_ptr
  import ram_rtl_pkg::*;
#(
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  inc_i,
  output logic [ADDR_WIDTH-1:0] ptr_o
);

  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;

  // Next pointer value: increment when enabled, otherwise hold.
  always_comb begin
    ptr_d = ptr_q;
    if (inc_i) begin
      ptr_d = ptr_q + ADDR_WIDTH'(1);
    end
  end

  // Pointer register with synchronous reset to address zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule : ram_fifo_ptr

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of the ram_4096 dual-port RAM. Converts a push
// stream and a pop request into RAM write/read strobes, tracks occupancy and
// returns popped words as a one-cycle pop_valid/pop_data beat.
//
// Handshakes: a push is taken on any cycle where push_valid and push_ready are
// both high (push_ready = !full); a pop is taken on any cycle where pop_req is
// high and the queue is not empty, signalled by pop_ack in that same cycle.
// The popped word follows RD_LATENCY+1 cycles later as a single pop_valid
// pulse; there is no back-pressure on the pop return path.
module ram_fifo_ctrl
  import ram_rtl_pkg::*;
#(
  parameter int DATA_WIDTH = RAM_DATA_WIDTH,
  parameter int ADDR_WIDTH = RAM_ADDR_WIDTH,
  parameter int DEPTH      = RAM_DEPTH,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push_valid,
  input  logic [DATA_WIDTH-1:0] push_data,
  output logic                  push_ready,
  input  logic                  pop_req,
  output logic                  pop_ack,
  output logic                  pop_valid,
  output logic [DATA_WIDTH-1:0] pop_data,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] wr_address,
  output logic [DATA_WIDTH-1:0] data_in,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] rd_address,
  input  logic [DATA_WIDTH-1:0] data_out
);

  localparam int CNT_W = ADDR_WIDTH + 1;

  logic                  push_acc;
  logic                  pop_acc;
  logic [ADDR_WIDTH-1:0] wr_ptr;
  logic [ADDR_WIDTH-1:0] rd_ptr;

  logic [CNT_W-1:0]      count_q;
  logic [CNT_W-1:0]      count_d;
  logic [RD_LATENCY-1:0] rd_pipe_q;
  logic [RD_LATENCY-1:0] rd_pipe_d;
  logic                  pop_valid_q;
  logic                  pop_valid_d;
  logic [DATA_WIDTH-1:0] pop_data_q;
  logic [DATA_WIDTH-1:0] pop_data_d;

  // Flags come only from the registered count, so they never glitch on pointer wrap.
  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);

  // Accepts are gated by the flags, which is what keeps the count in range and
  // rules out a same-address read/write.
  assign push_acc = push_valid & ~full;
  assign pop_acc  = pop_req & ~empty;

  ram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_wr_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (push_acc),
    .ptr_o (wr_ptr)
  );

  ram_fifo_ptr #(.ADDR_WIDTH(ADDR_WIDTH)) u_rd_ptr (
    .clk   (clk),
    .reset (reset),
    .inc_i (pop_acc),
    .ptr_o (rd_ptr)
  );

  // RAM port drive; addresses and write data are don't-care while the strobe is low.
  assign write      = push_acc;
  assign wr_address = wr_ptr;
  assign data_in    = push_data;
  assign read       = pop_acc;
  assign rd_address = rd_ptr;

  assign push_ready = ~full;
  assign pop_ack    = pop_acc;
  assign count      = count_q;
  assign pop_valid  = pop_valid_q;
  assign pop_data   = pop_data_q;

  // Occupancy: +1 on push only, -1 on pop only, unchanged when both or neither.
  always_comb begin
    count_d = count_q;
    unique case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Read-return tracking: shift each pop accept along a RD_LATENCY-deep pipe and
  // capture data_out when the accept reaches the last stage.
  always_comb begin
    rd_pipe_d   = RD_LATENCY'({rd_pipe_q, pop_acc});
    pop_valid_d = rd_pipe_q[RD_LATENCY-1];
    pop_data_d  = pop_data_q;
    if (rd_pipe_q[RD_LATENCY-1]) begin
      pop_data_d = data_out;
    end
  end

  // State registers; reset also discards any reads still in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q     <= '0;
      rd_pipe_q   <= '0;
      pop_valid_q <= 1'b0;
      pop_data_q  <= '0;
    end else begin
      count_q     <= count_d;
      rd_pipe_q   <= rd_pipe_d;
      pop_valid_q <= pop_valid_d;
      pop_data_q  <= pop_data_d;
    end
  end

endmodule : ram_fifo_ctrl

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: a behavioural 1-cycle-latency RAM, directed
// scenarios plus a random phase, all checked against a queue-based model.
module tb_ram_fifo_ctrl;

  localparam int DW    = 64;
  localparam int AW    = 12;
  localparam int DEPTH = 4096;
  localparam int RDL   = 1;

  logic          clk;
  logic          reset;
  logic          push_valid;
  logic [DW-1:0] push_data;
  logic          push_ready;
  logic          pop_req;
  logic          pop_ack;
  logic          pop_valid;
  logic [DW-1:0] pop_data;
  logic [AW:0]   count;
  logic          full;
  logic          empty;
  logic          write;
  logic [AW-1:0] wr_address;
  logic [DW-1:0] data_in;
  logic          read;
  logic [AW-1:0] rd_address;
  logic [DW-1:0] data_out;

  ram_fifo_ctrl #(
    .DATA_WIDTH (DW),
    .ADDR_WIDTH (AW),
    .DEPTH      (DEPTH),
    .RD_LATENCY (RDL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_data  (push_data),
    .push_ready (push_ready),
    .pop_req    (pop_req),
    .pop_ack    (pop_ack),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .write      (write),
    .wr_address (wr_address),
    .data_in    (data_in),
    .read       (read),
    .rd_address (rd_address),
    .data_out   (data_out)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural RAM, one cycle read latency.
  logic [DW-1:0] mem [0:DEPTH-1];
  always @(posedge clk) begin
    if (write) mem[wr_address] <= data_in;
    if (read)  data_out <= mem[rd_address];
  end

  // ---------------- scoreboard / model ----------------
  logic [DW-1:0] exp_q[$];      // words currently held by the FIFO
  logic [DW-1:0] ret_data_q[$]; // popped words awaiting their pop_valid beat
  int            ret_due_q[$];  // cycle at which each beat is due
  int            n_push;
  int            n_pop;
  int            cyc;
  int            n_checks;
  int            n_fail;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    ret_data_q.delete();
    ret_due_q.delete();
    n_push = 0;
    n_pop  = 0;
  endtask

  // ---------------- driver ----------------
  // One clock cycle: drive inputs, check all outputs against the model, advance.
  task automatic step(input logic rst, input logic pv, input logic [DW-1:0] pd, input logic pr);
    bit            e_push;
    bit            e_pop;
    int            occ;
    logic [DW-1:0] d;
    reset      = rst;
    push_valid = pv;
    push_data  = pd;
    pop_req    = pr;
    #3;
    occ    = exp_q.size();
    e_push = pv && (occ < DEPTH);
    e_pop  = pr && (occ > 0);
    check("push_ready", push_ready, DW'(occ < DEPTH));
    check("write", write, DW'(e_push));
    if (e_push) begin
      check("wr_address", wr_address, DW'(n_push % DEPTH));
      check("data_in", data_in, pd);
    end
    check("pop_ack", pop_ack, DW'(e_pop));
    check("read", read, DW'(e_pop));
    if (e_pop) check("rd_address", rd_address, DW'(n_pop % DEPTH));
    check("count", count, DW'(occ));
    check("empty", empty, DW'(occ == 0));
    check("full", full, DW'(occ == DEPTH));
    if (ret_due_q.size() > 0 && ret_due_q[0] == cyc) begin
      check("pop_valid", pop_valid, 1);
      check("pop_data", pop_data, ret_data_q[0]);
      void'(ret_due_q.pop_front());
      void'(ret_data_q.pop_front());
    end else begin
      check("pop_valid_idle", pop_valid, 0);
    end
    if (e_pop) begin
      d = exp_q.pop_front();
      ret_data_q.push_back(d);
      ret_due_q.push_back(cyc + RDL + 1);
      n_pop++;
    end
    if (e_push) begin
      exp_q.push_back(pd);
      n_push++;
    end
    if (rst) model_clear();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  function automatic logic [DW-1:0] rnd64();
    return {$urandom(), $urandom()};
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    n_checks = 0;
    n_fail   = 0;
    cyc      = 0;
    model_clear();
    reset      = 1'b1;
    push_valid = 1'b0;
    push_data  = '0;
    pop_req    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #2;
    check("rst_pop_data", pop_data, 0);
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    #1;

    // Single word round trip.
    step(0, 1, 64'hA5, 0);
    step(0, 0, '0, 1);
    repeat (3) step(0, 0, '0, 0);

    // Fill with data=index, push into full, push+pop while full.
    for (int i = 0; i < DEPTH; i++) step(0, 1, DW'(i), 0);
    step(0, 1, 64'hDEAD, 0);
    step(0, 1, 64'hBEEF, 1);
    step(0, 1, 64'hF00D, 0);
    // Drain back to back, then pop and push+pop while empty.
    for (int i = 0; i < DEPTH; i++) step(0, 0, '0, 1);
    repeat (3) step(0, 0, '0, 0);
    step(0, 0, '0, 1);
    step(0, 1, 64'h1234, 1);

    // Build to 10 entries, push+pop there.
    for (int i = 0; i < 9; i++) step(0, 1, rnd64(), 0);
    step(0, 1, rnd64(), 1);
    step(0, 1, rnd64(), 1);

    // Bring occupancy to 3, then run 5000 push/pop pairs across the wrap.
    while (exp_q.size() > 3) step(0, 0, '0, 1);
    for (int i = 0; i < 5000; i++) step(0, 1, rnd64(), 1);
    repeat (3) step(0, 0, '0, 0);

    // Random traffic.
    for (int i = 0; i < 3000; i++)
      step(0, $urandom_range(0, 99) < 55, rnd64(), $urandom_range(0, 99) < 50);

    // Reset one cycle after a pop accept.
    while (exp_q.size() < 4) step(0, 1, rnd64(), 0);
    step(0, 0, '0, 1);
    step(1, 0, '0, 0);
    step(0, 1, 64'h77, 0);
    step(0, 0, '0, 1);
    repeat (3) step(0, 0, '0, 0);

    check("end_ret_queue_empty", DW'(ret_due_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_ram_fifo_ctrl
